// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the program counter, captures ROM output into IF/ID, and
// handles stall, signed-direction redirects and halt-opcode detection.
module instruction_fetch_stage #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INST_WIDTH  = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 1,
  parameter logic [4:0]  HALT_OPCODE = 5'b11010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_base_pc,
  input  logic                  redirect_dir,
  input  logic [PC_WIDTH-1:0]   redirect_offset,
  output logic [PC_WIDTH-1:0]   rom_pc,
  input  logic [INST_WIDTH-1:0] rom_instruction,
  output logic [INST_WIDTH-1:0] ifid_instruction,
  output logic [PC_WIDTH-1:0]   ifid_pc,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic [PC_WIDTH-1:0]   fetch_count
);

  localparam int unsigned OPERAND_WIDTH = INST_WIDTH - 5;
  localparam logic [INST_WIDTH-1:0] RESET_INST = {HALT_OPCODE, {OPERAND_WIDTH{1'b0}}};

  logic [PC_WIDTH-1:0]   pc_reg, pc_next;
  logic [INST_WIDTH-1:0] ifid_instruction_reg, ifid_instruction_next;
  logic [PC_WIDTH-1:0]   ifid_pc_reg, ifid_pc_next;
  logic                  ifid_valid_reg, ifid_valid_next;
  logic                  halted_reg, halted_next;
  logic [PC_WIDTH-1:0]   fetch_count_reg, fetch_count_next;

  logic [PC_WIDTH-1:0]   redirect_target;
  logic                  is_halt;

  // Offset is unsigned; direction selects add or subtract, both wrap.
  assign redirect_target = redirect_dir ? (redirect_base_pc + redirect_offset)
                                        : (redirect_base_pc - redirect_offset);
  assign is_halt = (rom_instruction[INST_WIDTH-1:INST_WIDTH-5] == HALT_OPCODE);

  always_comb begin
    pc_next               = pc_reg;
    ifid_instruction_next = ifid_instruction_reg;
    ifid_pc_next          = ifid_pc_reg;
    ifid_valid_next       = ifid_valid_reg;
    halted_next           = halted_reg;
    fetch_count_next      = fetch_count_reg;

    if (redirect_valid) begin
      // Flush the wrong-path slot and squash any halt fetched on it.
      pc_next         = redirect_target;
      ifid_valid_next = 1'b0;
      halted_next     = 1'b0;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (halted_reg) begin
      ifid_valid_next = 1'b0;
    end else begin
      ifid_instruction_next = rom_instruction;
      ifid_pc_next          = pc_reg;
      ifid_valid_next       = 1'b1;
      fetch_count_next      = fetch_count_reg + PC_WIDTH'(1);
      if (is_halt) begin
        halted_next = 1'b1;
      end else begin
        pc_next = pc_reg + PC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg               <= RESET_PC;
      ifid_instruction_reg <= RESET_INST;
      ifid_pc_reg          <= '0;
      ifid_valid_reg       <= 1'b0;
      halted_reg           <= 1'b0;
      fetch_count_reg      <= '0;
    end else begin
      pc_reg               <= pc_next;
      ifid_instruction_reg <= ifid_instruction_next;
      ifid_pc_reg          <= ifid_pc_next;
      ifid_valid_reg       <= ifid_valid_next;
      halted_reg           <= halted_next;
      fetch_count_reg      <= fetch_count_next;
    end
  end

  assign rom_pc           = pc_reg;
  assign ifid_instruction = ifid_instruction_reg;
  assign ifid_pc          = ifid_pc_reg;
  assign ifid_valid       = ifid_valid_reg;
  assign halted           = halted_reg;
  assign fetch_count      = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: a behavioural ROM, a
// per-edge expectation queue, and explicit checks of the directed scenarios.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_base_pc;
  logic        redirect_dir;
  logic [15:0] redirect_offset;
  logic [15:0] rom_pc;
  logic [8:0]  rom_instruction;
  logic [8:0]  ifid_instruction;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [8:0]  instr;
    logic [15:0] ifpc;
    logic        valid;
    logic        halted;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];

  // Expected architectural state, tracked from the behavioural rules.
  logic [15:0] m_pc, m_ifpc, m_fc;
  logic [8:0]  m_instr;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_base_pc (redirect_base_pc),
    .redirect_dir     (redirect_dir),
    .redirect_offset  (redirect_offset),
    .rom_pc           (rom_pc),
    .rom_instruction  (rom_instruction),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  // Program occupies 1..200 with a halt at 74; everything else reads as halt.
  function automatic logic [8:0] rom_fn(input logic [15:0] a);
    if (a == 16'd74 || a == 16'd0 || a > 16'd200) return 9'b11010_0000;
    return {3'b001, a[1:0], a[3:0]};
  endfunction

  assign rom_instruction = rom_fn(rom_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'd1; m_instr = 9'b11010_0000; m_ifpc = 0; m_valid = 0; m_halted = 0; m_fc = 0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [15:0] b,
                            input logic d, input logic [15:0] o);
    logic [8:0] ins;
    if (rv) begin
      m_pc = d ? b + o : b - o; m_valid = 0; m_halted = 0;
    end else if (s) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 0;
    end else begin
      ins = rom_fn(m_pc);
      m_instr = ins; m_ifpc = m_pc; m_valid = 1; m_fc = m_fc + 16'd1;
      if (ins[8:4] == 5'b11010) m_halted = 1;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  // One clock: drive, predict, push, edge, pop and compare.
  task automatic cycle(input logic s, input logic rv, input logic [15:0] b,
                       input logic d, input logic [15:0] o);
    exp_t e;
    stall = s; redirect_valid = rv; redirect_base_pc = b; redirect_dir = d; redirect_offset = o;
    model_step(s, rv, b, d, o);
    exp_q.push_back('{m_pc, m_instr, m_ifpc, m_valid, m_halted, m_fc});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc", 32'(rom_pc), 32'(e.pc));
    check("ifid_instruction", 32'(ifid_instruction), 32'(e.instr));
    check("ifid_pc", 32'(ifid_pc), 32'(e.ifpc));
    check("ifid_valid", 32'(ifid_valid), 32'(e.valid));
    check("halted", 32'(halted), 32'(e.halted));
    check("fetch_count", 32'(fetch_count), 32'(e.fc));
    $display("cycle s=%0b rv=%0b pc=%0h ifid_pc=%0h v=%0b h=%0b fc=%0d",
             s, rv, rom_pc, ifid_pc, ifid_valid, halted, fetch_count);
    stall = 0; redirect_valid = 0;
  endtask

  task automatic normal(); cycle(0, 0, 0, 0, 0); endtask

  initial begin
    logic [15:0] fc_hold, ifpc_hold;
    reset = 1; stall = 0; redirect_valid = 0; redirect_base_pc = 0; redirect_dir = 0; redirect_offset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", 32'(rom_pc), 32'd1);
    check("reset_instr", 32'(ifid_instruction), 32'h1A0);
    check("reset_ifid_pc", 32'(ifid_pc), 32'd0);
    check("reset_valid", 32'(ifid_valid), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_fc", 32'(fetch_count), 32'd0);
    reset = 0;

    for (int i = 1; i <= 5; i++) begin
      normal();
      check("seq_ifid_pc", 32'(ifid_pc), 32'(i));
      check("seq_valid", 32'(ifid_valid), 32'd1);
    end
    check("seq_fc", 32'(fetch_count), 32'd5);

    cycle(0, 1, 16'd16, 1, 16'h3A);
    check("pos_redirect_pc", 32'(rom_pc), 32'd74);
    check("pos_redirect_bubble", 32'(ifid_valid), 32'd0);
    normal();
    check("halt_instr", 32'(ifid_instruction), 32'h1A0);
    check("halt_valid", 32'(ifid_valid), 32'd1);
    check("halt_flag", 32'(halted), 32'd1);
    repeat (2) begin
      normal();
      check("halt_bubble", 32'(ifid_valid), 32'd0);
      check("halt_pc_hold", 32'(rom_pc), 32'd74);
    end

    cycle(0, 1, 16'd73, 0, 16'd57);
    check("neg_redirect_pc", 32'(rom_pc), 32'd16);
    check("neg_redirect_bubble", 32'(ifid_valid), 32'd0);
    check("neg_redirect_unhalt", 32'(halted), 32'd0);
    normal();
    check("neg_target_valid", 32'(ifid_valid), 32'd1);
    repeat (3) normal();
    check("stall_start_pc", 32'(rom_pc), 32'd20);
    fc_hold = fetch_count; ifpc_hold = ifid_pc;
    repeat (3) begin
      cycle(1, 0, 0, 0, 0);
      check("stall_pc", 32'(rom_pc), 32'd20);
      check("stall_ifid_pc", 32'(ifid_pc), 32'(ifpc_hold));
      check("stall_fc", 32'(fetch_count), 32'(fc_hold));
    end
    cycle(1, 1, 16'd20, 1, 16'd10);
    check("stall_redirect_pc", 32'(rom_pc), 32'd30);

    cycle(0, 1, 16'hFFF0, 1, 16'h0020);
    check("wrap_pos", 32'(rom_pc), 32'h0010);
    cycle(0, 1, 16'd5, 0, 16'd10);
    check("wrap_neg", 32'(rom_pc), 32'hFFFB);
    normal();
    check("oob_halt", 32'(halted), 32'd1);
    normal();
    cycle(0, 1, 16'd0, 1, 16'd30);
    check("resume_unhalt", 32'(halted), 32'd0);
    normal();
    check("resume_ifid_pc", 32'(ifid_pc), 32'd30);
    normal();

    stall = 1;
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("async_pc", 32'(rom_pc), 32'd1);
    check("async_instr", 32'(ifid_instruction), 32'h1A0);
    check("async_ifid_pc", 32'(ifid_pc), 32'd0);
    check("async_valid", 32'(ifid_valid), 32'd0);
    check("async_fc", 32'(fetch_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 0; stall = 0;
    model_reset();
    normal();
    check("post_reset_ifid_pc", 32'(ifid_pc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
